// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the sequenced ALU control decoder: aluOp, funct and
// control-code constants, FSM states, and a small sizing helper.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_MUL     = 4'b1000;
    localparam logic [3:0] ALU_DIV     = 4'b1001;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Request/response bundle between the ID-stage control and the ALU control
// sequencer; master = issuing stage, slave = sequencer.
interface alu_control_seq_if;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_aluOp;
    logic [5:0] i_func;
    logic       i_flush;
    logic       o_valid;
    logic [3:0] o_aluControl;
    logic       o_busy;
    logic       o_done;
    logic       o_illegal;

    modport master (
        output i_valid, i_aluOp, i_func, i_flush,
        input  o_ready, o_valid, o_aluControl, o_busy, o_done, o_illegal
    );

    modport slave (
        input  i_valid, i_aluOp, i_func, i_flush,
        output o_ready, o_valid, o_aluControl, o_busy, o_done, o_illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS ALU control decode: aluOp + funct -> 4-bit code, with
// multi-cycle (mult/div) and illegal-encoding classification.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] i_aluOp,
    input  logic [5:0] i_func,
    output logic [3:0] o_code,
    output logic       o_is_multi,
    output logic       o_is_mul,
    output logic       o_is_illegal
);

    always_comb begin
        o_code       = ALU_ILLEGAL;
        o_is_multi   = 1'b0;
        o_is_mul     = 1'b0;
        o_is_illegal = 1'b0;
        case (i_aluOp)
            ALUOP_ADD: o_code = ALU_ADD;
            ALUOP_SUB: o_code = ALU_SUB;
            ALUOP_RTYPE: begin
                case (i_func)
                    FN_AND:  o_code = ALU_AND;
                    FN_OR:   o_code = ALU_OR;
                    FN_ADD:  o_code = ALU_ADD;
                    FN_SUB:  o_code = ALU_SUB;
                    FN_SLT:  o_code = ALU_SLT;
                    FN_NOR:  o_code = ALU_NOR;
                    FN_MULT: begin
                        o_code     = ALU_MUL;
                        o_is_multi = 1'b1;
                        o_is_mul   = 1'b1;
                    end
                    FN_DIV: begin
                        o_code     = ALU_DIV;
                        o_is_multi = 1'b1;
                    end
                    default: o_is_illegal = 1'b1;
                endcase
            end
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control sequencer: one-cycle decode plus a latency counter for mult/div.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to trap illegal encodings on o_illegal instead of forwarding code 1111.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    alu_control_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(max2(MUL_CYCLES, DIV_CYCLES));
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_code;
    logic             r_valid;
    logic             r_done;
    logic             r_illegal;

    logic [3:0]       w_code;
    logic             w_is_multi;
    logic             w_is_mul;
    logic             w_is_illegal;
    logic             w_ready;
    logic             w_accept;
    logic             w_trap;

    alu_ctrl_decode u_decode (
        .i_aluOp      (bus.i_aluOp),
        .i_func       (bus.i_func),
        .o_code       (w_code),
        .o_is_multi   (w_is_multi),
        .o_is_mul     (w_is_mul),
        .o_is_illegal (w_is_illegal)
    );

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    assign w_trap = w_is_illegal;
`else
    assign w_trap = 1'b0;
`endif

    assign w_ready  = (r_state == IDLE) & ~bus.i_flush;
    assign w_accept = bus.i_valid & w_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_code    <= ALU_ADD;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_trap) begin
                            r_illegal <= 1'b1;
                        end else begin
                            r_code  <= w_code;
                            r_valid <= 1'b1;
                            if (w_is_multi) begin
                                r_cnt   <= w_is_mul ? MUL_LOAD : DIV_LOAD;
                                r_state <= MULTI;
                            end
                        end
                    end
                end
                MULTI: begin
                    // done is registered one cycle early so it lands in the cycle the counter reads 0
                    if (bus.i_flush || (r_cnt == '0)) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1))
                            r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready      = w_ready;
    assign bus.o_valid      = r_valid;
    assign bus.o_aluControl = r_code;
    assign bus.o_busy       = (r_state == MULTI);
    assign bus.o_done       = r_done;
    assign bus.o_illegal    = r_illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: driver pushes expected outputs from a
// table-level reference model, a negedge monitor pops and compares them.
module tb_alu_control_seq;

    localparam int MUL_N = 4;
    localparam int DIV_N = 16;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot  = 0;

    alu_control_seq_if bus ();

    alu_control_seq #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        bit         ill;
    } exp_t;

    exp_t       vq[$];
    int         dq[$];
    int         m_acc = -1;
    int         m_end = -1;
    logic [3:0] m_code = 4'b0010;
    int         last_acc = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    endfunction

    function automatic void miss(input string name, input int exp_cyc);
        n_tot++;
        $display("FAIL %s: cycle %0d got nothing expected event at cycle %0d", name, cyc, exp_cyc);
    endfunction

    // Reference: the control-code table, plus the occupancy of multi-cycle ops.
    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                       output logic [3:0] code, output bit ill, output int n);
        n = 0; ill = 1'b0; code = 4'b1111;
        if (op == 2'd0) code = 4'b0010;
        else if (op == 2'd1) code = 4'b0110;
        else if (op == 2'd3) ill = 1'b1;
        else begin
            case (fn)
                6'b100100: code = 4'b0000;
                6'b100101: code = 4'b0001;
                6'b100000: code = 4'b0010;
                6'b100010: code = 4'b0110;
                6'b101010: code = 4'b0111;
                6'b100111: code = 4'b1100;
                6'b011000: begin code = 4'b1000; n = MUL_N; end
                6'b011010: begin code = 4'b1001; n = DIV_N; end
                default:   ill = 1'b1;
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (vq.size() > 0 && vq[0].cyc < cyc) begin
                miss("missing_out", vq[0].cyc);
                void'(vq.pop_front());
            end
            if (dq.size() > 0 && dq[0] < cyc) begin
                miss("missing_done", dq[0]);
                void'(dq.pop_front());
            end
            if (bus.o_valid || bus.o_illegal) begin
                if (vq.size() == 0) begin
                    chk("unexpected_out", int'({bus.o_valid, bus.o_illegal}), 0);
                end else begin
                    exp_t e;
                    e = vq.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("o_valid", int'(bus.o_valid), int'(!(TRAP && e.ill)));
                    chk("o_illegal", int'(bus.o_illegal), int'(TRAP && e.ill));
                    if (!(TRAP && e.ill)) chk("o_aluControl", int'(bus.o_aluControl), int'(e.code));
                end
            end
            if (bus.o_done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn,
                        input logic fl, output bit acc);
        logic [3:0] c;
        bit         ill;
        int         n;
        bit         busy_m;
        bus.i_valid = v; bus.i_aluOp = op; bus.i_func = fn; bus.i_flush = fl;
        @(negedge clk);
        busy_m = (cyc > m_acc) && (cyc <= m_end);
        chk("o_busy", int'(bus.o_busy), int'(busy_m));
        chk("o_ready", int'(bus.o_ready), int'(!busy_m && !fl));
        chk("code_hold", int'(bus.o_aluControl), int'(m_code));
        if (fl && busy_m && cyc < m_end) begin
            dq.delete(dq.size() - 1);
            m_end = cyc;
        end
        acc = v && !busy_m && !fl;
        if (acc) begin
            last_acc = cyc;
            ref_decode(op, fn, c, ill, n);
            vq.push_back('{cyc + 1, c, ill});
            if (!(TRAP && ill)) m_code = c;
            if (n > 0) begin
                m_acc = cyc;
                m_end = cyc + n;
                dq.push_back(cyc + n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 6'd0, 1'b0, a);
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] fn);
        bit a = 1'b0;
        for (int k = 0; k < 64 && !a; k++) step(1'b1, op, fn, 1'b0, a);
        if (!a) miss("issue_timeout", cyc);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        #1;
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_illegal", int'(bus.o_illegal), 0);
        chk("rst_code", int'(bus.o_aluControl), 2);
        chk("rst_ready", int'(bus.o_ready), 1);
        vq.delete(); dq.delete();
        m_acc = -1; m_end = -1; m_code = 4'b0010;
        repeat (hold) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1);
    end

    initial begin
        logic [5:0] sweep [6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111};
        logic [5:0] fns [8] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                                6'b101010, 6'b100111, 6'b011000, 6'b011010};
        int c0;
        bit a;
        bit have;
        logic [1:0] rop;
        logic [5:0] rfn;

        bus.i_valid = 1'b0; bus.i_aluOp = 2'd0; bus.i_func = 6'd0; bus.i_flush = 1'b0;
        #1;
        do_reset(2);
        idle(2);

        // reset in the middle of a div: no done may follow
        issue(2'b10, 6'b011010);
        idle(5);
        do_reset(2);
        idle(20);

        // R-type sweep, one per cycle
        for (int i = 0; i < 6; i++) begin
            c0 = last_acc;
            issue(2'b10, sweep[i]);
            if (i > 0) chk("sweep_rate", last_acc, c0 + 1);
        end
        idle(2);

        // mult with an add held behind it
        issue(2'b10, 6'b011000);
        c0 = last_acc;
        issue(2'b00, 6'd0);
        chk("held_add_acc", last_acc, c0 + MUL_N + 1);
        idle(2);

        // div flushed in cycle 6
        issue(2'b10, 6'b011010);
        c0 = last_acc;
        for (int k = 0; k < 20 && cyc < c0 + 6; k++) step(1'b0, 2'd0, 6'd0, 1'b0, a);
        step(1'b1, 2'b00, 6'd0, 1'b1, a);
        issue(2'b01, 6'd0);
        chk("post_flush_acc", last_acc, c0 + 7);
        idle(2);

        // illegal aluOp, illegal funct, then flush while idle
        issue(2'b11, 6'd0);
        issue(2'b10, 6'b111111);
        idle(1);
        step(1'b1, 2'b00, 6'd0, 1'b1, a);
        idle(2);

        // randomized traffic with held requests and sporadic flushes
        have = 1'b0; rop = 2'd0; rfn = 6'd0;
        for (int i = 0; i < 500; i++) begin
            if (!have && $urandom_range(3) != 0) begin
                have = 1'b1;
                rop  = 2'($urandom_range(3));
                rfn  = ($urandom_range(3) == 0) ? 6'($urandom) : fns[$urandom_range(7)];
            end
            step(have, rop, rfn, ($urandom_range(19) == 0), a);
            if (a) have = 1'b0;
        end
        idle(DIV_N + 4);

        chk("outq_empty", vq.size(), 0);
        chk("doneq_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
